// File: rtl/tx_burst_pkg.sv
// Shared definitions for the transmit burst generator.
// State encoding and default counter widths.
package tx_burst_pkg;

  localparam int TX_CNT_W   = 16;
  localparam int TX_BURST_W = 8;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_PULSE_HI = 2'd1;
  localparam logic [1:0] ST_PULSE_LO = 2'd2;
  localparam logic [1:0] ST_BLANK    = 2'd3;

endpackage

// File: rtl/tx_burst_gen_phase_counter.sv
// Loadable down-counter timing the pulse phases and the blank window.
// tc marks the last cycle of the loaded interval (count == 1).
module tx_phase_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt;
  logic [W-1:0] one;

  assign one = {{(W-1){1'b0}}, 1'b1};
  assign tc  = (cnt == one);

  // Load has priority; otherwise step down toward 1 and hold there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt > one)) begin
      cnt <= cnt - one;
    end
  end

endmodule

// File: rtl/tx_burst_gen.sv
// Probe burst generator: N square pulses of programmable half-period,
// receiver blanking, start strobe and done pulse. Optional TX_BURST_ABORT_EN.
module tx_burst_gen
  import tx_burst_pkg::*;
#(
  parameter int CNT_W   = TX_CNT_W,
  parameter int BURST_W = TX_BURST_W
) (
  input  logic               clk,
  input  logic               rst,
`ifdef TX_BURST_ABORT_EN
  input  logic               abort,
`endif
  input  logic               start,
  input  logic [CNT_W-1:0]   half_period,
  input  logic [BURST_W-1:0] n_pulses,
  input  logic [CNT_W-1:0]   blank_len,
  output logic               tx_out,
  output logic               tx_start_strobe,
  output logic               blank,
  output logic               busy,
  output logic               done
);

  logic [1:0]         state;
  logic [1:0]         nxt;
  logic [CNT_W-1:0]   hp_r;
  logic [CNT_W-1:0]   bl_r;
  logic [CNT_W-1:0]   hp_in;
  logic [CNT_W-1:0]   ld_val;
  logic [BURST_W-1:0] rem;
  logic               tc;
  logic               ld;
  logic               en;
  logic               last;
  logic               accept;
  logic               abort_hit;
  logic               tx_d;
  logic               strobe_d;
  logic               blank_d;
  logic               busy_d;
  logic               done_d;

  assign hp_in = (half_period == '0) ?
                 {{(CNT_W-1){1'b0}}, 1'b1} : half_period;
  assign accept = start && (n_pulses != '0);
  assign last = (rem == {{(BURST_W-1){1'b0}}, 1'b1});

`ifdef TX_BURST_ABORT_EN
  assign abort_hit = abort && (state != ST_IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= nxt;
    end
  end

  // Next-state decode; abort overrides everything outside IDLE.
  always_comb begin
    nxt = state;
    if (abort_hit) begin
      nxt = ST_IDLE;
    end else begin
      unique case (1'b1)
        (state == ST_IDLE): begin
          if (accept) nxt = ST_PULSE_HI;
        end
        (state == ST_PULSE_HI): begin
          if (tc) nxt = ST_PULSE_LO;
        end
        (state == ST_PULSE_LO): begin
          if (tc) begin
            if (!last) nxt = ST_PULSE_HI;
            else if (bl_r != '0) nxt = ST_BLANK;
            else nxt = ST_IDLE;
          end
        end
        (state == ST_BLANK): begin
          if (tc) nxt = ST_IDLE;
        end
        default: nxt = ST_IDLE;
      endcase
    end
  end

  // Output decode from the next state so outputs align with state entry.
  always_comb begin
    tx_d     = (nxt == ST_PULSE_HI);
    strobe_d = (state == ST_IDLE) && (nxt == ST_PULSE_HI);
    blank_d  = (nxt != ST_IDLE);
    busy_d   = (nxt != ST_IDLE);
    done_d   = (state != ST_IDLE) && (nxt == ST_IDLE) && !abort_hit;
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_out          <= 1'b0;
      tx_start_strobe <= 1'b0;
      blank           <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      tx_out          <= tx_d;
      tx_start_strobe <= strobe_d;
      blank           <= blank_d;
      busy            <= busy_d;
      done            <= done_d;
    end
  end

  // Burst parameters are frozen at acceptance; pulse count steps per pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hp_r <= '0;
      bl_r <= '0;
      rem  <= '0;
    end else if ((state == ST_IDLE) && (nxt == ST_PULSE_HI)) begin
      hp_r <= hp_in;
      bl_r <= blank_len;
      rem  <= n_pulses;
    end else if ((state == ST_PULSE_LO) && tc && (rem != '0)) begin
      rem  <= rem - 1'b1;
    end
  end

  // Reload the phase timer on every state change.
  always_comb begin
    ld = (nxt != state);
    en = (state != ST_IDLE);
    if (nxt == ST_BLANK) ld_val = bl_r;
    else if (state == ST_IDLE) ld_val = hp_in;
    else ld_val = hp_r;
  end

  tx_phase_counter #(
    .W(CNT_W)
  ) u_phase (
    .clk      (clk),
    .rst      (rst),
    .load     (ld),
    .en       (en),
    .load_val (ld_val),
    .tc       (tc)
  );

endmodule

// File: tb/tb_tx_burst_gen.sv
// Testbench for tx_burst_gen: directed plus random bursts
// checked against an arithmetic burst-timeline model.
module tb_tx_burst_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        abort = 1'b0;
  logic        start = 1'b0;
  logic [15:0] half_period = '0;
  logic [7:0]  n_pulses = '0;
  logic [15:0] blank_len = '0;
  logic        tx_out;
  logic        tx_start_strobe;
  logic        blank;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rises = 0;
  logic prev_tx = 1'b0;

  // Model: a burst is a timeline of offsets k from its first cycle.
  bit m_act = 0;
  int m_k = 0;
  int m_hp = 1;
  int m_n = 0;
  int m_bl = 0;
  int m_tot = 0;

  always #5 clk = ~clk;

  tx_burst_gen dut (
    .clk             (clk),
    .rst             (rst),
`ifdef TX_BURST_ABORT_EN
    .abort           (abort),
`endif
    .start           (start),
    .half_period     (half_period),
    .n_pulses        (n_pulses),
    .blank_len       (blank_len),
    .tx_out          (tx_out),
    .tx_start_strobe (tx_start_strobe),
    .blank           (blank),
    .busy            (busy),
    .done            (done)
  );

  task automatic model_step();
    bit idle;
    bit ab;
    idle = !m_act || (m_k == m_tot);
`ifdef TX_BURST_ABORT_EN
    ab = abort;
`else
    ab = 1'b0;
`endif
    if (rst) begin
      m_act = 0;
    end else if (!idle && ab) begin
      m_act = 0;
    end else if (idle && start && (n_pulses != 0)) begin
      m_hp  = (half_period == 0) ? 1 : int'(half_period);
      m_n   = int'(n_pulses);
      m_bl  = int'(blank_len);
      m_tot = 2 * m_hp * m_n + m_bl;
      m_k   = 0;
      m_act = 1;
    end else if (m_act) begin
      if (m_k == m_tot) m_act = 0;
      else m_k++;
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    logic e_busy, e_tx, e_str, e_done;
    e_busy = m_act && (m_k < m_tot);
    e_tx   = m_act && (m_k < 2 * m_hp * m_n) && ((m_k % (2 * m_hp)) < m_hp);
    e_str  = m_act && (m_k == 0);
    e_done = m_act && (m_k == m_tot);
    chk("tx_out", tx_out, e_tx);
    chk("strobe", tx_start_strobe, e_str);
    chk("blank", blank, e_busy);
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    if (tx_out && !prev_tx) rises++;
    prev_tx = tx_out;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic setp(input int hp, input int n, input int bl);
    half_period = 16'(hp);
    n_pulses    = 8'(n);
    blank_len   = 16'(bl);
  endtask

  initial begin
    // Reset state
    #1;
    check_all();
    run(2);
    #2 rst = 1'b0;

    // Nominal burst: hp=4 N=3 BL=10
    setp(4, 3, 10);
    start = 1'b1;
    step();
    start = 1'b0;
    run(40);

    // hp=0 behaves as 1
    setp(0, 1, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    run(5);

    // N=0 is ignored
    setp(3, 0, 4);
    start = 1'b1;
    run(6);
    start = 1'b0;
    run(2);

    // Held start, mid-burst half_period change, back-to-back burst
    setp(2, 2, 0);
    start = 1'b1;
    run(3);
    half_period = 16'd7;
    run(6);
    half_period = 16'd2;
    run(3);
    start = 1'b0;
    run(12);

    // Async reset in the middle of PULSE_HI
    setp(4, 3, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    run(2);
    #2 rst = 1'b1;
    #1;
    m_act = 0;
    check_all();
    #2 rst = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    run(28);

    // Maximum pulse count
    setp(1, 255, 0);
    rises = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    run(515);
    checks++;
    assert (rises === 255) else begin
      errors++;
      $error("FAIL max_rises observed=%0d expected=%0d", rises, 255);
    end

`ifdef TX_BURST_ABORT_EN
    // Abort in cycle 6 of the nominal burst
    setp(4, 3, 10);
    start = 1'b1;
    step();
    start = 1'b0;
    run(5);
    abort = 1'b1;
    step();
    abort = 1'b0;
    run(40);
`endif

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      start = ($urandom_range(0, 3) == 0);
      setp($urandom_range(0, 4), $urandom_range(0, 3),
           $urandom_range(0, 5));
`ifdef TX_BURST_ABORT_EN
      abort = ($urandom_range(0, 40) == 0);
`endif
      step();
    end
    start = 1'b0;
    abort = 1'b0;
    run(60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_burst_gen.md
Name: tx_burst_gen

Overview:
- Transmit-side companion of the echo threshold trigger: generates the rangefinder probe burst, a fixed number of square pulses at a programmable half-period.
- Drives a receiver blanking window so the echo trigger ignores transmitter feedthrough.
- Emits a one-cycle strobe at burst start that the time-of-flight counter uses as its zero reference.
- Sits between the control registers and the transducer driver pin.

Parameters:
- CNT_W, 16, width of the half_period and blank_len counters.
- BURST_W, 8, width of the pulse-count field.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a burst; sampled every cycle.
- half_period  in  CNT_W  cycles per high phase and per low phase; 0 is treated as 1.
- n_pulses  in  BURST_W  number of high/low pulse pairs; 0 means start is ignored.
- blank_len  in  CNT_W  extra blanking cycles after the last low phase.
- tx_out  out  1  transducer drive, registered.
- tx_start_strobe  out  1  one-cycle pulse coincident with the first high cycle of tx_out.
- blank  out  1  receiver blanking, high from the first tx_out high cycle to the end of the blank window.
- busy  out  1  high while the FSM is outside IDLE.
- done  out  1  one-cycle pulse after the burst and blank window complete.

Behaviour:
- Reset: asynchronous, effective immediately, including mid-burst. State goes to IDLE. tx_out, tx_start_strobe, blank, busy and done are all 0. Counters clear.
- FSM states: IDLE, PULSE_HI, PULSE_LO, BLANK.
- All outputs are registered and derived from the next-state decode, so they change on the edge that enters each state.
- IDLE: on start=1 with n_pulses!=0:
  - latch hp=max(half_period,1), N=n_pulses and BL=blank_len; later input changes have no effect on the running burst;
  - go to PULSE_HI;
  - tx_out=1, tx_start_strobe=1, blank=1 and busy=1 take effect on the following cycle, i.e. one cycle of latency from start.
- start with n_pulses=0 is ignored: no outputs change and done is not produced.
- PULSE_HI: tx_out=1 for exactly hp cycles, then go to PULSE_LO.
- PULSE_LO: tx_out=0 for exactly hp cycles, then decrement the remaining-pulse count.
  - Count not yet zero: go to PULSE_HI.
  - Count zero and BL>0: go to BLANK.
  - Count zero and BL=0: go to IDLE.
- BLANK: tx_out=0 and blank=1 for exactly BL cycles, then go to IDLE.
- Entering IDLE from an active state: done=1 for one cycle; blank=0 and busy=0 in that same cycle.
- Total busy length is 2*hp*N+BL cycles.
- start while busy=1 is ignored and not queued. start in the done cycle is accepted, because the FSM is already in IDLE.
- tx_start_strobe is high only in the first PULSE_HI cycle of a burst.
- Counters count down from the load value to 1 using CNT_W-bit arithmetic with no wrap. The pulse counter is BURST_W bits, so the maximum of 255 pulses is supported with no overflow.

Optional Feature:
- Macro: TX_BURST_ABORT_EN.
- When defined: adds input port abort (1 bit, sampled every cycle).
  - abort=1 in any non-IDLE state forces IDLE on the next edge, with tx_out=0, blank=0 and busy=0.
  - done is not pulsed after an abort.
  - abort has priority over start in the same cycle.
  - abort in IDLE has no effect.
- When not defined: no abort port; a burst always runs to completion, and only rst can stop it.

Decomposition:
- Shared package tx_burst_pkg holds:
  - the state encoding localparams ST_IDLE, ST_PULSE_HI, ST_PULSE_LO, ST_BLANK (2 bits);
  - the default widths CNT_W and BURST_W.
- One sub-module, tx_phase_counter: a loadable CNT_W down-counter with load, enable and a terminal-count flag.
  - It is reused for the phase timing and the blank timing.
  - The pulse counter stays inline in tx_burst_gen.

Test Plan:
- Reset: assert rst mid-PULSE_HI with hp=4, N=3 -> all outputs 0 without waiting for a clock edge; FSM in IDLE; the next start runs a full burst.
- Nominal burst: hp=4, N=3, BL=10, start at cycle 0.
  - tx_out high in cycles 1-4, 9-12 and 17-20, low otherwise.
  - tx_start_strobe only in cycle 1.
  - blank and busy high in cycles 1-34.
  - done only in cycle 35.
- Boundary inputs:
  - hp=0, N=1, BL=0 -> tx_out high in cycle 1, low in cycle 2, done in cycle 3.
  - N=0 -> no activity and no done.
- Ignored and back-to-back starts: hp=2, N=2, BL=0, BL-independent timing.
  - Hold start high for the whole burst -> exactly one burst, done in cycle 9.
  - The start sampled in cycle 9 launches a second burst with tx_out high in cycle 10.
  - Changing half_period mid-burst has no effect.
- Maximum count: N=255, hp=1, BL=0 -> exactly 255 rising edges on tx_out; done at cycle 511.
- TX_BURST_ABORT_EN: abort in cycle 6 of the nominal burst -> cycle 7 shows tx_out=0, blank=0, busy=0; no done ever appears.
